fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline with a 2-bit-counter branch target buffer (BTB). Holds the PC, reads instruction memory, predicts the next PC, and drives the IF/ID pipeline register (instruction, PC, PC+4, predictor hit) consumed by the decode stage. Hazard control supplies stall and flush; execute supplies redirect and predictor-update information.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- BTB_ENTRIES, 16: BTB depth; power of two, at least 2. IDX_W = log2(BTB_ENTRIES).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- imem_addr_o  out  32  fetch address; equals the current PC, combinational.
- imem_data_i  in  32  instruction word; combinational read of imem_addr_o.
- enable_i  in  1  1 = advance the PC and the IF/ID register; 0 = stall and hold both.
- reset_i  in  1  flush of the IF/ID register; acts only when enable_i = 1.
- redirect_i  in  1  execute-stage mispredict; load redirect_pc_i into the PC.
- redirect_pc_i  in  32  corrected PC.
- bp_update_i  in  1  a resolved control-transfer instruction is in execute.
- bp_pc_i  in  32  PC of that instruction.
- bp_target_i  in  32  its resolved target.
- bp_taken_i  in  1  its resolved direction.
- inst_d_o  out  32  IF/ID instruction.
- pc_d_o  out  32  IF/ID PC.
- pc4_d_o  out  32  IF/ID PC+4.
- hit_d_o  out  1  IF/ID predicted-taken flag.

## Operation
- **BTB entry fields:** valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0].
- **Lookup index:** pc[IDX_W+1:2].
- **Prediction (combinational on the current PC):**
  - hit = valid && tag match && ctr[1].
  - pred_pc = hit ? target : pc + 4.
  - Arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- **Next PC priority:**
  1. redirect_i = 1: PC ← redirect_pc_i. Overrides stall.
  2. Otherwise enable_i = 1: PC ← pred_pc.
  3. Otherwise: hold.
- **IF/ID register:**
  - enable_i = 0: hold all fields.
  - enable_i = 1 and reset_i = 1: all fields ← 0. The all-zero word is the pipeline bubble.
  - enable_i = 1 and reset_i = 0: inst ← imem_data_i, pc ← PC, pc4 ← PC + 4, hit ← hit.
- **BTB update (when bp_update_i = 1, independent of enable_i):**
  - Entry tag matches bp_pc_i and valid:
    - ctr saturating +1 if bp_taken_i, saturating −1 otherwise (range 0..3).
    - target ← bp_target_i if bp_taken_i.
  - Entry misses and bp_taken_i = 1: allocate (replace). valid ← 1, tag, target ← bp_target_i, ctr ← 2'b10.
  - Entry misses and bp_taken_i = 0: no change.
- Hazard/redirect generation belongs to other units. This block only obeys the inputs.

## Timing
- **Reset (asynchronous, immediate on rst_ni low):**
  - PC = RESET_PC; imem_addr_o = RESET_PC.
  - inst_d_o, pc_d_o, pc4_d_o = 0; hit_d_o = 0.
  - All BTB valid = 0. Counters and targets need no reset.
- **Latency:**
  - Fetch address to IF/ID outputs: 1 cycle.
  - BTB update is visible to lookups starting the next cycle.
- **Same-cycle lookup and update of one index:** lookup returns the pre-update contents.
- **redirect_i with enable_i = 1 and reset_i = 1 (normal mispredict flush):** the bubble enters IF/ID while the PC loads the redirect target.
- **Simultaneous redirect_i and bp_update_i:** both take effect.
- **Reset mid-operation:** discards any pending redirect or update.

## Test plan
- **Reset and sequential fetch:** rst_ni low, then high, imem returns 32'h00000013, enable_i = 1.
  - Cycle 1: pc_d_o = 0, pc4_d_o = 4, hit_d_o = 0.
  - Cycle 2: pc_d_o = 4.
- **Stall:** enable_i = 0 for 3 cycles at PC 0x10 → imem_addr_o stays 0x10 and IF/ID outputs are unchanged; on release, pc_d_o = 0x10 on the next edge.
- **Flush:** reset_i = 1, enable_i = 1 → next cycle all IF/ID outputs are 0. With reset_i = 1, enable_i = 0 → IF/ID outputs are unchanged.
- **Allocate and predict:** bp_update_i with bp_pc_i = 0x20, target 0x80, taken = 1. Later fetch of 0x20 → hit_d_o = 1 and the following fetch address is 0x80.
- **Counter hysteresis:** on the entry from the previous scenario:
  - One not-taken update (ctr = 1) → fetch of 0x20 predicts 0x24.
  - Two taken updates (ctr = 3), then one not-taken (ctr = 2) → still predicts 0x80.
  - Three more not-taken updates → ctr saturates at 0.
- **Redirect priority and aliasing:**
  - redirect_i = 1, redirect_pc_i = 0x200 while enable_i = 0 → PC = 0x200 next cycle.
  - A tag mismatch at the same index (e.g. bp_pc_i = 0x60 with 16 entries, aliasing 0x20) gives no hit.
  - PC 32'hFFFF_FFFC sequential → next PC 0.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 5-stage RV32I pipeline. Holds the PC, presents
// it to instruction memory, predicts the next PC with a direct-mapped branch
// target buffer (2-bit saturating counters), and registers the fetched word
// into the IF/ID pipeline register for the decode stage.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   imem_addr_o    fetch address (current PC, combinational)
//   imem_data_i    instruction word read combinationally at imem_addr_o
//   enable_i       1 = advance PC and IF/ID, 0 = stall (hold both)
//   reset_i        flush IF/ID to the all-zero bubble (only when enable_i = 1)
//   redirect_i     load redirect_pc_i into the PC (wins over stall)
//   redirect_pc_i  corrected PC from execute
//   bp_update_i    resolved control transfer present in execute
//   bp_pc_i        PC of the resolved instruction
//   bp_target_i    resolved target
//   bp_taken_i     resolved direction
//   inst_d_o       IF/ID instruction
//   pc_d_o         IF/ID PC
//   pc4_d_o        IF/ID PC+4
//   hit_d_o        IF/ID predicted-taken flag
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   input  logic        enable_i,
   input  logic        reset_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        bp_update_i,
   input  logic [31:0] bp_pc_i,
   input  logic [31:0] bp_target_i,
   input  logic        bp_taken_i,
   output logic [31:0] inst_d_o,
   output logic [31:0] pc_d_o,
   output logic [31:0] pc4_d_o,
   output logic        hit_d_o
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;

   // Saturating 2-bit counter step: up on taken, down on not-taken.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != 2'b11) res = ctr + 2'b01;
      end else begin
         if (ctr != 2'b00) res = ctr - 2'b01;
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- state
   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic [31:0] pred_pc;

   logic [31:0] inst_reg;
   logic [31:0] pc_d_reg;
   logic [31:0] pc4_d_reg;
   logic        hit_d_reg;

   // Flattened view of the BTB entries, driven from the per-entry generate blocks.
   logic             entry_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] entry_tag    [BTB_ENTRIES];
   logic [31:0]      entry_target [BTB_ENTRIES];
   logic [1:0]       entry_ctr    [BTB_ENTRIES];

   // ---------------------------------------------------------------- lookup
   logic [IDX_W-1:0] look_idx;
   logic [TAG_W-1:0] look_tag;
   logic             hit;

   assign look_idx = pc_reg[IDX_W+1:2];
   assign look_tag = pc_reg[31:IDX_W+2];

   // Valid is checked first so unwritten tag/counter contents never matter.
   assign hit      = entry_valid[look_idx]
                     && (entry_tag[look_idx] == look_tag)
                     && entry_ctr[look_idx][1];
   assign pc_plus4 = pc_reg + 32'd4;
   assign pred_pc  = hit ? entry_target[look_idx] : pc_plus4;

   assign imem_addr_o = pc_reg;

   // ---------------------------------------------------------------- next PC
   always_comb begin
      pc_next = pc_reg;
      if (redirect_i) begin
         pc_next = redirect_pc_i;
      end else if (enable_i) begin
         pc_next = pred_pc;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_reg <= RESET_PC;
      end else begin
         pc_reg <= pc_next;
      end
   end

   // ---------------------------------------------------------------- IF/ID
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inst_reg  <= '0;
         pc_d_reg  <= '0;
         pc4_d_reg <= '0;
         hit_d_reg <= 1'b0;
      end else if (enable_i) begin
         if (reset_i) begin
            // All-zero word is the pipeline bubble.
            inst_reg  <= '0;
            pc_d_reg  <= '0;
            pc4_d_reg <= '0;
            hit_d_reg <= 1'b0;
         end else begin
            inst_reg  <= imem_data_i;
            pc_d_reg  <= pc_reg;
            pc4_d_reg <= pc_plus4;
            hit_d_reg <= hit;
         end
      end
   end

   assign inst_d_o = inst_reg;
   assign pc_d_o   = pc_d_reg;
   assign pc4_d_o  = pc4_d_reg;
   assign hit_d_o  = hit_d_reg;

   // ---------------------------------------------------------------- update
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_match;

   assign upd_idx   = bp_pc_i[IDX_W+1:2];
   assign upd_tag   = bp_pc_i[31:IDX_W+2];
   assign upd_match = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

   // Word-aligned PCs: the two low bits of bp_pc_i carry no information.
   logic unused_bp_pc_lsb;
   assign unused_bp_pc_lsb = ^bp_pc_i[1:0];

   genvar gi;
   generate
      for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
         logic             valid_reg;
         logic [TAG_W-1:0] tag_reg;
         logic [31:0]      target_reg;
         logic [1:0]       ctr_reg;
         logic             sel;

         assign sel = bp_update_i && (upd_idx == IDX_W'(gi));

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               valid_reg <= 1'b0;
            end else if (sel && !upd_match && bp_taken_i) begin
               valid_reg <= 1'b1;
            end
         end

         // Payload is not reset; gating with rst_ni keeps an update that
         // coincides with reset from touching the entry.
         always_ff @(posedge clk_i) begin
            if (sel && rst_ni) begin
               if (upd_match) begin
                  ctr_reg <= ctr_step(ctr_reg, bp_taken_i);
                  if (bp_taken_i) begin
                     target_reg <= bp_target_i;
                  end
               end else if (bp_taken_i) begin
                  // Replace whatever occupied this index, weakly taken.
                  tag_reg    <= upd_tag;
                  target_reg <= bp_target_i;
                  ctr_reg    <= 2'b10;
               end
            end
         end

         assign entry_valid[gi]  = valid_reg;
         assign entry_tag[gi]    = tag_reg;
         assign entry_target[gi] = target_reg;
         assign entry_ctr[gi]    = ctr_reg;
      end
   endgenerate

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Instruction memory returns {addr[19:0],12'h013}
// so the fetched word identifies its own address (address 0 gives 32'h00000013).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk_i;
   logic        rst_ni;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic        enable_i;
   logic        reset_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        bp_update_i;
   logic [31:0] bp_pc_i;
   logic [31:0] bp_target_i;
   logic        bp_taken_i;
   logic [31:0] inst_d_o;
   logic [31:0] pc_d_o;
   logic [31:0] pc4_d_o;
   logic        hit_d_o;

   int checks = 0;
   int errors = 0;

   fetch_stage #(
      .RESET_PC    (32'h0000_0000),
      .BTB_ENTRIES (16)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .imem_addr_o   (imem_addr_o),
      .imem_data_i   (imem_data_i),
      .enable_i      (enable_i),
      .reset_i       (reset_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .bp_update_i   (bp_update_i),
      .bp_pc_i       (bp_pc_i),
      .bp_target_i   (bp_target_i),
      .bp_taken_i    (bp_taken_i),
      .inst_d_o      (inst_d_o),
      .pc_d_o        (pc_d_o),
      .pc4_d_o       (pc4_d_o),
      .hit_d_o       (hit_d_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   assign imem_data_i = {imem_addr_o[19:0], 12'h013};

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One cycle of predictor training with the PC frozen.
   task automatic bp_train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
      enable_i    = 1'b0;
      bp_update_i = 1'b1;
      bp_pc_i     = pc;
      bp_target_i = tgt;
      bp_taken_i  = taken;
      tick();
      bp_update_i = 1'b0;
      bp_taken_i  = 1'b0;
      enable_i    = 1'b1;
      $display("txn train pc=%h tgt=%h taken=%0b", pc, tgt, taken);
   endtask

   // Redirect to addr, then fetch it; afterwards IF/ID holds addr and
   // imem_addr_o shows the predicted successor.
   task automatic fetch_at(input logic [31:0] addr);
      enable_i      = 1'b1;
      reset_i       = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = addr;
      tick();
      redirect_i    = 1'b0;
      tick();
      $display("txn fetch pc=%h hit=%0b next=%h", pc_d_o, hit_d_o, imem_addr_o);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; enable_i = 1'b0; reset_i = 1'b0; redirect_i = 1'b0;
      redirect_pc_i = '0; bp_update_i = 1'b0; bp_pc_i = '0; bp_target_i = '0; bp_taken_i = 1'b0;
      #3;
      checks++;
      if (imem_addr_o !== 32'h0) begin
         errors++; $display("FAIL reset_addr: got %h want %h", imem_addr_o, 32'h0);
      end
      checks++;
      if ({inst_d_o, pc_d_o, pc4_d_o, hit_d_o} !== 97'h0) begin
         errors++; $display("FAIL reset_ifid: got inst=%h pc=%h pc4=%h hit=%0b want all 0",
                            inst_d_o, pc_d_o, pc4_d_o, hit_d_o);
      end
      tick();
      rst_ni   = 1'b1;
      enable_i = 1'b1;
      $display("txn reset released");
   endtask

   task automatic test_seq_fetch();
      tick();
      checks++;
      if ({inst_d_o, pc_d_o, pc4_d_o, hit_d_o} !== {32'h0000_0013, 32'h0, 32'h4, 1'b0}) begin
         errors++; $display("FAIL seq_c1: got inst=%h pc=%h pc4=%h hit=%0b want 00000013/0/4/0",
                            inst_d_o, pc_d_o, pc4_d_o, hit_d_o);
      end
      tick();
      checks++;
      if ({pc_d_o, inst_d_o, imem_addr_o} !== {32'h4, 32'h0000_4013, 32'h8}) begin
         errors++; $display("FAIL seq_c2: got pc=%h inst=%h addr=%h want 4/00004013/8",
                            pc_d_o, inst_d_o, imem_addr_o);
      end
      tick();
      tick();
      checks++;
      if ({pc_d_o, imem_addr_o} !== {32'hC, 32'h10}) begin
         errors++; $display("FAIL seq_c4: got pc=%h addr=%h want c/10", pc_d_o, imem_addr_o);
      end
      $display("txn sequential fetch done pc_d=%h", pc_d_o);
   endtask

   task automatic test_stall();
      enable_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({imem_addr_o, pc_d_o, inst_d_o} !== {32'h10, 32'hC, 32'h0000_C013}) begin
            errors++; $display("FAIL stall_%0d: got addr=%h pc=%h inst=%h want 10/c/0000c013",
                               i, imem_addr_o, pc_d_o, inst_d_o);
         end
      end
      enable_i = 1'b1;
      tick();
      checks++;
      if ({pc_d_o, imem_addr_o} !== {32'h10, 32'h14}) begin
         errors++; $display("FAIL stall_release: got pc=%h addr=%h want 10/14", pc_d_o, imem_addr_o);
      end
      $display("txn stall released pc_d=%h", pc_d_o);
   endtask

   task automatic test_flush();
      reset_i = 1'b1;
      tick();
      checks++;
      if ({inst_d_o, pc_d_o, pc4_d_o, hit_d_o, imem_addr_o} !== {97'h0, 32'h18}) begin
         errors++; $display("FAIL flush_bubble: got inst=%h pc=%h pc4=%h hit=%0b addr=%h want 0/0/0/0/18",
                            inst_d_o, pc_d_o, pc4_d_o, hit_d_o, imem_addr_o);
      end
      reset_i = 1'b0;
      tick();
      reset_i  = 1'b1;
      enable_i = 1'b0;
      tick();
      checks++;
      if ({inst_d_o, pc_d_o, pc4_d_o, imem_addr_o} !== {32'h0001_8013, 32'h18, 32'h1C, 32'h1C}) begin
         errors++; $display("FAIL flush_stalled: got inst=%h pc=%h pc4=%h addr=%h want 00018013/18/1c/1c",
                            inst_d_o, pc_d_o, pc4_d_o, imem_addr_o);
      end
      reset_i = 1'b0;
      $display("txn flush done");
   endtask

   task automatic test_allocate();
      bp_train(32'h20, 32'h80, 1'b1);
      tick();
      checks++;
      if ({pc_d_o, hit_d_o, imem_addr_o} !== {32'h1C, 1'b0, 32'h20}) begin
         errors++; $display("FAIL alloc_pre: got pc=%h hit=%0b addr=%h want 1c/0/20",
                            pc_d_o, hit_d_o, imem_addr_o);
      end
      tick();
      checks++;
      if ({pc_d_o, hit_d_o, imem_addr_o} !== {32'h20, 1'b1, 32'h80}) begin
         errors++; $display("FAIL alloc_hit: got pc=%h hit=%0b addr=%h want 20/1/80",
                            pc_d_o, hit_d_o, imem_addr_o);
      end
      tick();
      checks++;
      if ({pc_d_o, hit_d_o, imem_addr_o} !== {32'h80, 1'b0, 32'h84}) begin
         errors++; $display("FAIL alloc_target: got pc=%h hit=%0b addr=%h want 80/0/84",
                            pc_d_o, hit_d_o, imem_addr_o);
      end
      $display("txn allocate done");
   endtask

   task automatic test_hysteresis();
      bp_train(32'h20, 32'h80, 1'b0);                 // ctr 2 -> 1
      fetch_at(32'h20);
      checks++;
      if ({pc_d_o, hit_d_o, imem_addr_o} !== {32'h20, 1'b0, 32'h24}) begin
         errors++; $display("FAIL hyst_weak_nt: got pc=%h hit=%0b addr=%h want 20/0/24",
                            pc_d_o, hit_d_o, imem_addr_o);
      end
      for (int i = 0; i < 3; i++) bp_train(32'h20, 32'h80, 1'b1);  // 1 -> 2 -> 3 -> 3
      bp_train(32'h20, 32'h80, 1'b0);                 // 3 -> 2
      fetch_at(32'h20);
      checks++;
      if ({hit_d_o, imem_addr_o} !== {1'b1, 32'h80}) begin
         errors++; $display("FAIL hyst_strong: got hit=%0b addr=%h want 1/80", hit_d_o, imem_addr_o);
      end
      for (int i = 0; i < 3; i++) bp_train(32'h20, 32'h80, 1'b0);  // 2 -> 1 -> 0 -> 0
      fetch_at(32'h20);
      checks++;
      if ({hit_d_o, imem_addr_o} !== {1'b0, 32'h24}) begin
         errors++; $display("FAIL hyst_zero: got hit=%0b addr=%h want 0/24", hit_d_o, imem_addr_o);
      end
      bp_train(32'h20, 32'h90, 1'b1);                 // 0 -> 1
      fetch_at(32'h20);
      checks++;
      if ({hit_d_o, imem_addr_o} !== {1'b0, 32'h24}) begin
         errors++; $display("FAIL hyst_sat_low: got hit=%0b addr=%h want 0/24", hit_d_o, imem_addr_o);
      end
      bp_train(32'h20, 32'h90, 1'b1);                 // 1 -> 2, new target
      fetch_at(32'h20);
      checks++;
      if ({hit_d_o, imem_addr_o} !== {1'b1, 32'h90}) begin
         errors++; $display("FAIL hyst_retarget: got hit=%0b addr=%h want 1/90", hit_d_o, imem_addr_o);
      end
   endtask

   task automatic test_redirect();
      // PC = 0x90, IF/ID holds 0x20 with hit = 1.
      enable_i      = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      tick();
      checks++;
      if ({imem_addr_o, pc_d_o, hit_d_o} !== {32'h200, 32'h20, 1'b1}) begin
         errors++; $display("FAIL redir_stall: got addr=%h pc=%h hit=%0b want 200/20/1",
                            imem_addr_o, pc_d_o, hit_d_o);
      end
      redirect_i = 1'b0;
      enable_i   = 1'b1;
      tick();
      checks++;
      if ({pc_d_o, imem_addr_o} !== {32'h200, 32'h204}) begin
         errors++; $display("FAIL redir_fetch: got pc=%h addr=%h want 200/204", pc_d_o, imem_addr_o);
      end
      $display("txn redirect during stall pc_d=%h", pc_d_o);

      fetch_at(32'h60);                               // same index as 0x20, other tag
      checks++;
      if ({pc_d_o, hit_d_o, imem_addr_o} !== {32'h60, 1'b0, 32'h64}) begin
         errors++; $display("FAIL alias: got pc=%h hit=%0b addr=%h want 60/0/64",
                            pc_d_o, hit_d_o, imem_addr_o);
      end

      redirect_i    = 1'b1;
      redirect_pc_i = 32'h300;
      reset_i       = 1'b1;
      tick();
      checks++;
      if ({inst_d_o, pc_d_o, pc4_d_o, hit_d_o, imem_addr_o} !== {97'h0, 32'h300}) begin
         errors++; $display("FAIL redir_flush: got inst=%h pc=%h pc4=%h hit=%0b addr=%h want 0/0/0/0/300",
                            inst_d_o, pc_d_o, pc4_d_o, hit_d_o, imem_addr_o);
      end
      reset_i = 1'b0;
      $display("txn mispredict flush addr=%h", imem_addr_o);

      redirect_pc_i = 32'h100;
      bp_update_i   = 1'b1;
      bp_pc_i       = 32'h100;
      bp_target_i   = 32'h340;
      bp_taken_i    = 1'b1;
      tick();
      redirect_i  = 1'b0;
      bp_update_i = 1'b0;
      checks++;
      if (imem_addr_o !== 32'h100) begin
         errors++; $display("FAIL redir_upd_pc: got %h want %h", imem_addr_o, 32'h100);
      end
      tick();
      checks++;
      if ({pc_d_o, hit_d_o, imem_addr_o} !== {32'h100, 1'b1, 32'h340}) begin
         errors++; $display("FAIL redir_upd_hit: got pc=%h hit=%0b addr=%h want 100/1/340",
                            pc_d_o, hit_d_o, imem_addr_o);
      end
      $display("txn redirect plus update pc_d=%h", pc_d_o);

      // Lookup and allocation of the same index in one cycle.
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h44;
      tick();
      redirect_i  = 1'b0;
      bp_update_i = 1'b1;
      bp_pc_i     = 32'h44;
      bp_target_i = 32'h500;
      bp_taken_i  = 1'b1;
      tick();
      bp_update_i = 1'b0;
      checks++;
      if ({pc_d_o, hit_d_o, imem_addr_o} !== {32'h44, 1'b0, 32'h48}) begin
         errors++; $display("FAIL same_cycle: got pc=%h hit=%0b addr=%h want 44/0/48",
                            pc_d_o, hit_d_o, imem_addr_o);
      end
      fetch_at(32'h44);
      checks++;
      if ({hit_d_o, imem_addr_o} !== {1'b1, 32'h500}) begin
         errors++; $display("FAIL same_cycle_after: got hit=%0b addr=%h want 1/500", hit_d_o, imem_addr_o);
      end
   endtask

   task automatic test_wrap();
      fetch_at(32'hFFFF_FFFC);
      checks++;
      if ({pc_d_o, pc4_d_o, inst_d_o, imem_addr_o} !== {32'hFFFF_FFFC, 32'h0, 32'hFFFF_C013, 32'h0}) begin
         errors++; $display("FAIL wrap: got pc=%h pc4=%h inst=%h addr=%h want fffffffc/0/ffffc013/0",
                            pc_d_o, pc4_d_o, inst_d_o, imem_addr_o);
      end
   endtask

   task automatic test_reset_mid();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h700;
      bp_update_i   = 1'b1;
      bp_pc_i       = 32'h80;
      bp_target_i   = 32'h900;
      bp_taken_i    = 1'b1;
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({imem_addr_o, inst_d_o, pc_d_o, pc4_d_o, hit_d_o} !== 129'h0) begin
         errors++; $display("FAIL async_reset: got addr=%h inst=%h pc=%h pc4=%h hit=%0b want all 0",
                            imem_addr_o, inst_d_o, pc_d_o, pc4_d_o, hit_d_o);
      end
      tick();
      checks++;
      if (imem_addr_o !== 32'h0) begin
         errors++; $display("FAIL reset_hold: got %h want %h", imem_addr_o, 32'h0);
      end
      redirect_i  = 1'b0;
      bp_update_i = 1'b0;
      bp_taken_i  = 1'b0;
      rst_ni      = 1'b1;
      $display("txn reset mid-operation released");
      fetch_at(32'h20);
      checks++;
      if ({hit_d_o, imem_addr_o} !== {1'b0, 32'h24}) begin
         errors++; $display("FAIL reset_btb: got hit=%0b addr=%h want 0/24", hit_d_o, imem_addr_o);
      end
      fetch_at(32'h80);
      checks++;
      if ({hit_d_o, imem_addr_o} !== {1'b0, 32'h84}) begin
         errors++; $display("FAIL reset_drop_upd: got hit=%0b addr=%h want 0/84", hit_d_o, imem_addr_o);
      end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_stall();
      test_flush();
      test_allocate();
      test_hysteresis();
      test_redirect();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
